uart_pin_receiver: RTL and testbench

- UART 8N1 receiver that is the far end of the pin-state transfer link. The transmitting board sends ASCII '0' (0x30) or '1' (0x31) every 0.5 s.
- Deserialises each byte, validates framing, and drives a local output pin that mirrors the remote pin.
- A link watchdog forces the pin to a safe value and drops LINK_OK when updates stop arriving.

---
 rtl/uart_pin_receiver.sv | 174 +++++++++++++++++
 tb/tb_uart_pin_receiver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pin_receiver.sv
`timescale 1ns/1ps
// uart_pin_receiver
//
// Far end of the pin-state transfer link. An 8N1 UART byte stream carries
// ASCII '0' (0x30) or '1' (0x31). Each correctly framed byte is presented on
// rx_byte with a one-cycle rx_valid strobe. A valid command drives the local
// mirror pin. A watchdog falls back to SAFE_VALUE and drops link_ok when
// commands stop arriving for TIMEOUT cycles.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   defined   - every start/data/stop sample is the 2-of-3 majority of the
//               synchronised line over the sample cycle and the two before it
//   undefined - single sample of the synchronised line on the sample cycle
//
// Ports:
//   clk        system clock (12 MHz nominal)
//   rst        asynchronous active-high reset
//   rx         UART line, idle high, asynchronous to clk
//   pin_out    mirrored remote pin state
//   link_ok    high while valid commands keep arriving within TIMEOUT
//   rx_byte    last correctly framed byte
//   rx_valid   one-cycle strobe, rx_byte updated on the same cycle
//   frame_err  one-cycle strobe when the stop bit is sampled low
//   cmd_err    one-cycle strobe when a framed byte is not 0x30/0x31
module uart_pin_receiver #(
  parameter int   BAUD_DIV   = 104,
  parameter int   TIMEOUT    = 18_000_000,
  parameter logic SAFE_VALUE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       pin_out,
  output logic       link_ok,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       cmd_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state;
  logic [1:0]    sync_q;
  logic          rxs;
  logic          sample_bit;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_done;
  logic [WW-1:0] wd;
  logic          is_cmd;

  // Two-flop synchroniser, preset high so reset looks like an idle line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end

  assign rxs = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // Two previous values of rxs; together with the current one they vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], rxs};
  end

  assign sample_bit = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
  assign sample_bit = rxs;
`endif

  assign is_cmd = byte_done && ((shreg == 8'h30) || (shreg == 8'h31));

  // Receive FSM, byte presentation, command decode and link watchdog.
  // A good stop bit only raises byte_done; the strobe and the decode happen
  // one clock later, at the same edge the FSM returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_done <= 1'b0;
      wd        <= '0;
      pin_out   <= SAFE_VALUE;
      link_ok   <= 1'b0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      cmd_err   <= 1'b0;
      byte_done <= 1'b0;

      if (byte_done) begin
        rx_valid <= 1'b1;
        rx_byte  <= shreg;
        if (!is_cmd) cmd_err <= 1'b1;
      end

      // A valid command beats a simultaneous expiry.
      if (is_cmd) begin
        wd      <= '0;
        link_ok <= 1'b1;
        pin_out <= shreg[0];
      end else if (wd == WD_MAX) begin
        link_ok <= 1'b0;
        pin_out <= SAFE_VALUE;
      end else begin
        wd <= wd + 1'b1;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= sample_bit ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {sample_bit, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (byte_done) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == FULL_M1) begin
            cnt <= '0;
            if (sample_bit) begin
              byte_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pin_receiver.sv
`timescale 1ns/1ps
// tb_uart_pin_receiver
//
// Scoreboard bench for uart_pin_receiver built with TIMEOUT=5000. The
// stimulus process queues the strobe each frame should produce; a monitor
// on the falling clock edge pops and compares whenever rx_valid or
// frame_err is seen. Pin/link state is checked directly by the stimulus.
module tb_uart_pin_receiver;

  localparam int BAUD_DIV = 104;
  localparam int TIMEOUT  = 5000;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       pin_out;
  logic       link_ok;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       cmd_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       is_frame_err;
    logic [7:0] data;
    logic       cmd_err;
  } exp_t;

  exp_t exp_q[$];

  uart_pin_receiver #(
    .BAUD_DIV  (BAUD_DIV),
    .TIMEOUT   (TIMEOUT),
    .SAFE_VALUE(1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .pin_out  (pin_out),
    .link_ok  (link_ok),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .cmd_err  (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push_expect(input logic fe, input logic [7:0] data, input logic ce);
    exp_t e;
    e.is_frame_err = fe;
    e.data         = data;
    e.cmd_err      = ce;
    exp_q.push_back(e);
  endtask

  // Hold rx at v for n clock cycles; always returns 1 ns after a rising edge.
  task automatic drive_line(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame, LSB first, with a selectable stop bit level.
  task automatic apply_stimulus(input logic [7:0] data, input logic stop_val);
    drive_line(1'b0, BAUD_DIV);
    for (int i = 0; i < 8; i++) drive_line(data[i], BAUD_DIV);
    drive_line(stop_val, BAUD_DIV);
  endtask

  // Scoreboard monitor.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && prev_valid) begin
        checks++;
        failures++;
        $display("[TB] FAIL valid_width: rx_valid high 2 cycles at %0t", $time);
      end
      if (rx_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_strobe: valid=%0b frame_err=%0b byte=0x%02h required none",
                   rx_valid, frame_err, rx_byte);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("strobe_kind", {6'd0, rx_valid, frame_err},
                       e.is_frame_err ? 8'd1 : 8'd2);
          if (!e.is_frame_err) begin
            check_output("rx_byte", rx_byte, e.data);
            check_output("cmd_err", {7'd0, cmd_err}, {7'd0, e.cmd_err});
          end
        end
      end else if (cmd_err) begin
        checks++;
        failures++;
        $display("[TB] FAIL stray_cmd_err: cmd_err=1 without rx_valid at %0t", $time);
      end
      prev_valid <= rx_valid;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  logic strobe_seen;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_output("reset_pin_out",   {7'd0, pin_out},   8'd0);
    check_output("reset_link_ok",   {7'd0, link_ok},   8'd0);
    check_output("reset_rx_byte",   rx_byte,           8'h00);
    check_output("reset_rx_valid",  {7'd0, rx_valid},  8'd0);
    check_output("reset_frame_err", {7'd0, frame_err}, 8'd0);
    check_output("reset_cmd_err",   {7'd0, cmd_err},   8'd0);
    rst = 1'b0;
    drive_line(1'b1, 20);

    $display("[TB] single 0x31");
    push_expect(1'b0, 8'h31, 1'b0);
    apply_stimulus(8'h31, 1'b1);
    check_output("t1_pin_out", {7'd0, pin_out}, 8'd1);
    check_output("t1_link_ok", {7'd0, link_ok}, 8'd1);
    drive_line(1'b1, 30);

    $display("[TB] back-to-back 0x31 0x30");
    push_expect(1'b0, 8'h31, 1'b0);
    push_expect(1'b0, 8'h30, 1'b0);
    apply_stimulus(8'h31, 1'b1);
    apply_stimulus(8'h30, 1'b1);
    check_output("t2_pin_out", {7'd0, pin_out}, 8'd0);
    check_output("t2_link_ok", {7'd0, link_ok}, 8'd1);
    drive_line(1'b1, 30);

    $display("[TB] bad command 0x41 after 0x31");
    push_expect(1'b0, 8'h31, 1'b0);
    push_expect(1'b0, 8'h41, 1'b1);
    apply_stimulus(8'h31, 1'b1);
    apply_stimulus(8'h41, 1'b1);
    check_output("t3_pin_out", {7'd0, pin_out}, 8'd1);
    check_output("t3_link_ok", {7'd0, link_ok}, 8'd1);
    check_output("t3_rx_byte", rx_byte, 8'h41);
    drive_line(1'b1, 30);

    $display("[TB] 20-cycle glitch then 0x30");
    drive_line(1'b0, 20);
    drive_line(1'b1, 200);
    push_expect(1'b0, 8'h30, 1'b0);
    apply_stimulus(8'h30, 1'b1);
    check_output("t4_pin_out", {7'd0, pin_out}, 8'd0);
    check_output("t4_rx_byte", rx_byte, 8'h30);
    drive_line(1'b1, 30);

    $display("[TB] framing error and break, then 0x30");
    push_expect(1'b1, 8'h00, 1'b0);
    apply_stimulus(8'h31, 1'b0);
    drive_line(1'b0, 3000);
    check_output("t5_rx_byte_kept", rx_byte, 8'h30);
    drive_line(1'b1, 50);
    push_expect(1'b0, 8'h30, 1'b0);
    apply_stimulus(8'h30, 1'b1);
    check_output("t5_rx_byte", rx_byte, 8'h30);
    check_output("t5_pin_out", {7'd0, pin_out}, 8'd0);
    check_output("t5_link_ok", {7'd0, link_ok}, 8'd1);
    drive_line(1'b1, 30);

    $display("[TB] watchdog expiry after 0x31");
    push_expect(1'b0, 8'h31, 1'b0);
    strobe_seen = 1'b0;
    fork
      apply_stimulus(8'h31, 1'b1);
      begin
        for (int i = 0; i < 3 * BAUD_DIV * 10; i++) begin
          @(posedge clk);
          #1;
          if (rx_valid) begin
            strobe_seen = 1'b1;
            break;
          end
        end
        if (strobe_seen) begin
          repeat (TIMEOUT) @(posedge clk);
          #1;
          check_output("t6_link_before", {7'd0, link_ok}, 8'd1);
          check_output("t6_pin_before",  {7'd0, pin_out}, 8'd1);
          @(posedge clk);
          #1;
          check_output("t6_link_after", {7'd0, link_ok}, 8'd0);
          check_output("t6_pin_after",  {7'd0, pin_out}, 8'd0);
        end
      end
    join
    check_output("t6_strobe_seen", {7'd0, strobe_seen}, 8'd1);
    drive_line(1'b1, 30);

    $display("[TB] reset mid data bit");
    push_expect(1'b0, 8'h31, 1'b0);
    apply_stimulus(8'h31, 1'b1);
    check_output("t7_pin_pre", {7'd0, pin_out}, 8'd1);
    drive_line(1'b1, 30);
    drive_line(1'b0, BAUD_DIV);
    drive_line(1'b1, BAUD_DIV);
    drive_line(1'b0, BAUD_DIV / 2);
    rst = 1'b1;
    #1;
    check_output("t7_rst_pin_out",  {7'd0, pin_out},  8'd0);
    check_output("t7_rst_link_ok",  {7'd0, link_ok},  8'd0);
    check_output("t7_rst_rx_byte",  rx_byte,          8'h00);
    check_output("t7_rst_rx_valid", {7'd0, rx_valid}, 8'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_line(1'b1, 20);
    push_expect(1'b0, 8'h31, 1'b0);
    apply_stimulus(8'h31, 1'b1);
    check_output("t7_pin_out", {7'd0, pin_out}, 8'd1);
    check_output("t7_link_ok", {7'd0, link_ok}, 8'd1);
    check_output("t7_rx_byte", rx_byte, 8'h31);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    check_output("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
